// File: rtl/sram_access_controller_pkg.sv
// Shared constants and state encoding for the MEM-stage SRAM access controller.
package sram_access_controller_pkg;
    localparam int          SRAM_DATA_LEN     = 16;
    localparam int          SRAM_ADDR_LEN_DEF = 18;
    localparam int          SRAM_WAIT_CYCLES  = 4;
    localparam logic [31:0] SRAM_BASE_ADDR    = 32'd1024;

    typedef enum logic [1:0] {
        SRAM_IDLE = 2'd0,
        SRAM_LOW  = 2'd1,
        SRAM_HIGH = 2'd2,
        SRAM_DONE = 2'd3
    } sram_state_e;
endpackage

// File: rtl/sram_access_controller.sv
// Splits each 32-bit LDR/STR into two wait-stated half-word SRAM accesses and
// holds ready low until the word is complete.
module sram_access_controller
    import sram_access_controller_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR     = SRAM_BASE_ADDR,
    parameter int          WAIT_CYCLES   = SRAM_WAIT_CYCLES,
    parameter int          SRAM_ADDR_LEN = SRAM_ADDR_LEN_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     mem_read,
    input  logic                     mem_write,
    input  logic [31:0]              address,
    input  logic [31:0]              write_data,
    output logic [31:0]              read_data,
    output logic                     ready,
    output logic [SRAM_ADDR_LEN-1:0] sram_addr,
    output logic [SRAM_DATA_LEN-1:0] sram_dq_out,
    input  logic [SRAM_DATA_LEN-1:0] sram_dq_in,
    output logic                     sram_dq_oe,
    output logic                     sram_we_n,
    output logic                     sram_oe_n
);
    localparam int            CW       = $clog2(WAIT_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_CYCLES - 1);

    sram_state_e              state_q, state_d;
    logic [CW-1:0]            cnt_q, cnt_d;
    logic                     is_wr_q, is_wr_d;
    logic [SRAM_ADDR_LEN-2:0] word_q, word_d;
    logic [31:0]              wdata_q, wdata_d;
    logic [31:0]              read_data_q, read_data_d;
    logic [SRAM_ADDR_LEN-1:0] sram_addr_q, sram_addr_d;
    logic [SRAM_DATA_LEN-1:0] sram_dq_out_q, sram_dq_out_d;
    logic                     sram_dq_oe_q, sram_dq_oe_d;
    logic                     sram_we_n_q, sram_we_n_d;
    logic                     sram_oe_n_q, sram_oe_n_d;

    logic        req;
    logic [31:0] phys;
    logic        active, hi;
    logic        unused_phys;

    assign req         = mem_read | mem_write;
    assign phys        = address - BASE_ADDR;
    assign unused_phys = ^{phys[31:SRAM_ADDR_LEN+1], phys[1:0]};

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        is_wr_d     = is_wr_q;
        word_d      = word_q;
        wdata_d     = wdata_q;
        read_data_d = read_data_q;
        case (state_q)
            SRAM_IDLE: if (req) begin
                state_d = SRAM_LOW;
                cnt_d   = '0;
                is_wr_d = mem_write;
                word_d  = phys[SRAM_ADDR_LEN:2];
                wdata_d = write_data;
            end
            SRAM_LOW: if (cnt_q == CNT_LAST) begin
                if (!is_wr_q) read_data_d[15:0] = sram_dq_in;
                state_d = SRAM_HIGH;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
            SRAM_HIGH: if (cnt_q == CNT_LAST) begin
                if (!is_wr_q) read_data_d[31:16] = sram_dq_in;
                state_d = SRAM_DONE;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
            SRAM_DONE: state_d = SRAM_IDLE;
            default:   state_d = SRAM_IDLE;
        endcase

        // Pin values are derived from the next state so they are registered
        // and line up with the cycle the FSM enters each phase.
        active        = (state_d == SRAM_LOW) || (state_d == SRAM_HIGH);
        hi            = (state_d == SRAM_HIGH);
        sram_addr_d   = active ? {word_d, hi} : '0;
        sram_dq_out_d = (active && is_wr_d) ? (hi ? wdata_d[31:16] : wdata_d[15:0]) : '0;
        sram_dq_oe_d  = active && is_wr_d;
        sram_we_n_d   = !(active && is_wr_d && (cnt_d != '0));
        sram_oe_n_d   = !(active && !is_wr_d);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= SRAM_IDLE;
            cnt_q         <= '0;
            is_wr_q       <= 1'b0;
            word_q        <= '0;
            wdata_q       <= '0;
            read_data_q   <= '0;
            sram_addr_q   <= '0;
            sram_dq_out_q <= '0;
            sram_dq_oe_q  <= 1'b0;
            sram_we_n_q   <= 1'b1;
            sram_oe_n_q   <= 1'b1;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            is_wr_q       <= is_wr_d;
            word_q        <= word_d;
            wdata_q       <= wdata_d;
            read_data_q   <= read_data_d;
            sram_addr_q   <= sram_addr_d;
            sram_dq_out_q <= sram_dq_out_d;
            sram_dq_oe_q  <= sram_dq_oe_d;
            sram_we_n_q   <= sram_we_n_d;
            sram_oe_n_q   <= sram_oe_n_d;
        end
    end

    assign ready       = (state_q == SRAM_DONE) || ((state_q == SRAM_IDLE) && !req);
    assign read_data   = read_data_q;
    assign sram_addr   = sram_addr_q;
    assign sram_dq_out = sram_dq_out_q;
    assign sram_dq_oe  = sram_dq_oe_q;
    assign sram_we_n   = sram_we_n_q;
    assign sram_oe_n   = sram_oe_n_q;
endmodule
